// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types and constants for the enemy motion block
package enemy_pkg;

  // Vertical motion state of the enemy sprite.
  typedef enum logic [1:0] {
    ST_GROUNDED = 2'd0,
    ST_RISING   = 2'd1,
    ST_FALLING  = 2'd2
  } enemy_mv_t;

  // Pixel coordinate (11 bits covers a 2048-pixel playfield).
  typedef logic [10:0] pos_t;

  // Tiles are 16x16 pixels; tile index = position >> TILE_SHIFT.
  localparam int unsigned TILE_SHIFT = 4;

  // Lowest y the enemy may fall to: the top pixel row of the last tile row.
  localparam pos_t Y_FALL_LIMIT = 11'h7F0;

  // Drop the sub-tile bits so the sprite sits exactly on a tile boundary.
  function automatic pos_t snap_to_tile(input pos_t p);
    return (p >> TILE_SHIFT) << TILE_SHIFT;
  endfunction

endpackage

// File: rtl/enemy_motion_if.sv
// rtl/enemy_motion_if.sv - frame/control inputs and position outputs of enemy_motion
interface enemy_motion_if;
  import enemy_pkg::*;

  logic        frame_tick;
  logic        jump;
  logic [1:0]  enemy_dir;
  logic        on_ground;
  pos_t        enemy_x;
  pos_t        enemy_y;
  logic [13:0] enemy_loc;
  logic        airborne;

  // Game-logic side: supplies ticks and decisions, consumes position.
  modport master (
    output frame_tick, jump, enemy_dir, on_ground,
    input  enemy_x, enemy_y, enemy_loc, airborne
  );

  // Motion block side.
  modport slave (
    input  frame_tick, jump, enemy_dir, on_ground,
    output enemy_x, enemy_y, enemy_loc, airborne
  );

endinterface

// File: rtl/enemy_x_step.sv
// rtl/enemy_x_step.sv - saturating one-frame horizontal step
module enemy_x_step
  import enemy_pkg::*;
(
  input  pos_t       i_x,
  input  logic [1:0] i_dir,
  input  pos_t       i_speed,
  input  pos_t       i_max,
  output pos_t       o_x_next
);

  // One extra bit so the rightward sum cannot wrap before the compare.
  logic [11:0] w_sum;

  assign w_sum = {1'b0, i_x} + {1'b0, i_speed};

  // 01 steps right clamped at i_max, 10 steps left clamped at 0, else hold.
  always_comb begin
    o_x_next = i_x;
    case (i_dir)
      2'b01: o_x_next = (w_sum > {1'b0, i_max}) ? i_max : w_sum[10:0];
      2'b10: o_x_next = (i_x < i_speed) ? '0 : (i_x - i_speed);
      default: o_x_next = i_x;
    endcase
  end

endmodule

// File: rtl/enemy_motion.sv
// rtl/enemy_motion.sv - per-frame enemy position update with jump/fall physics
module enemy_motion
  import enemy_pkg::*;
#(
  parameter pos_t        X_INIT   = 11'd64,
  parameter pos_t        Y_INIT   = 11'd64,
  parameter pos_t        X_MAX    = 11'd2032,
  parameter int unsigned H_SPEED  = 2,
  parameter int unsigned JUMP_V   = 8,
  parameter int unsigned MAX_FALL = 6
) (
  input  logic           Clk,
  input  logic           Reset,
  enemy_motion_if.slave  bus
);

  localparam pos_t L_H_SPEED  = pos_t'(H_SPEED);
  localparam pos_t L_JUMP_V   = pos_t'(JUMP_V);
  localparam pos_t L_MAX_FALL = pos_t'(MAX_FALL);

  enemy_mv_t r_state;
  enemy_mv_t w_state_nxt;
  pos_t      r_x;
  pos_t      r_y;
  pos_t      r_vy;
  logic      r_jump_pend;
  pos_t      w_x_nxt;
  pos_t      w_y_nxt;
  pos_t      w_vy_nxt;
  logic      w_jump_req;
  logic [11:0] w_y_sum;

  // A request pending from earlier in the frame or arriving on the tick itself.
  assign w_jump_req = r_jump_pend | bus.jump;
  assign w_y_sum    = {1'b0, r_y} + {1'b0, r_vy};

  enemy_x_step u_x_step (
    .i_x      (r_x),
    .i_dir    (bus.enemy_dir),
    .i_speed  (L_H_SPEED),
    .i_max    (X_MAX),
    .o_x_next (w_x_nxt)
  );

  // Next vertical state, position and speed for the coming frame tick.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_vy_nxt    = r_vy;
    case (r_state)
      ST_GROUNDED: begin
        if (w_jump_req) begin
          w_state_nxt = ST_RISING;
          w_vy_nxt    = L_JUMP_V;
        end else if (!bus.on_ground) begin
          w_state_nxt = ST_FALLING;
          w_vy_nxt    = 11'd1;
        end
      end
      ST_RISING: begin
        if (r_y < r_vy) begin
          // Hit the top of the screen: stop the rise and start falling.
          w_y_nxt     = '0;
          w_state_nxt = ST_FALLING;
          w_vy_nxt    = 11'd1;
        end else begin
          w_y_nxt = r_y - r_vy;
          if (r_vy <= 11'd2) begin
            // Speed would decay to 1: the apex, hand over to the fall.
            w_state_nxt = ST_FALLING;
            w_vy_nxt    = 11'd1;
          end else begin
            w_vy_nxt = r_vy - 11'd1;
          end
        end
      end
      ST_FALLING: begin
        if (bus.on_ground) begin
          w_y_nxt     = snap_to_tile(r_y);
          w_vy_nxt    = '0;
          w_state_nxt = ST_GROUNDED;
        end else begin
          w_y_nxt  = (w_y_sum > {1'b0, Y_FALL_LIMIT}) ? Y_FALL_LIMIT : w_y_sum[10:0];
          w_vy_nxt = (r_vy >= L_MAX_FALL) ? L_MAX_FALL : (r_vy + 11'd1);
        end
      end
      default: begin
        w_state_nxt = ST_FALLING;
        w_vy_nxt    = '0;
      end
    endcase
  end

  // Motion state advances only on frame ticks.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_FALLING;
      r_x     <= X_INIT;
      r_y     <= Y_INIT;
      r_vy    <= '0;
    end else if (bus.frame_tick) begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_vy    <= w_vy_nxt;
    end
  end

  // Remember a jump seen between ticks; each tick consumes or discards it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_jump_pend <= 1'b0;
    end else if (bus.frame_tick) begin
      r_jump_pend <= 1'b0;
    end else if (bus.jump) begin
      r_jump_pend <= 1'b1;
    end
  end

  assign bus.enemy_x   = r_x;
  assign bus.enemy_y   = r_y;
  assign bus.enemy_loc = {r_y[10:TILE_SHIFT], r_x[10:TILE_SHIFT]};
  assign bus.airborne  = (r_state != ST_GROUNDED);

endmodule

// File: tb/tb_enemy_motion.sv
// tb/tb_enemy_motion.sv - directed vector bench for enemy_motion
module tb_enemy_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       jump = 1'b0;
  logic       on_ground = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [1:0] dir_hi = 2'b00;
  logic [1:0] dir_lo = 2'b00;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  enemy_motion_if ifc ();
  enemy_motion_if ifc_hi ();
  enemy_motion_if ifc_lo ();

  assign ifc.frame_tick    = frame_tick;
  assign ifc.jump          = jump;
  assign ifc.on_ground     = on_ground;
  assign ifc.enemy_dir     = dir;
  assign ifc_hi.frame_tick = frame_tick;
  assign ifc_hi.jump       = jump;
  assign ifc_hi.on_ground  = on_ground;
  assign ifc_hi.enemy_dir  = dir_hi;
  assign ifc_lo.frame_tick = frame_tick;
  assign ifc_lo.jump       = jump;
  assign ifc_lo.on_ground  = on_ground;
  assign ifc_lo.enemy_dir  = dir_lo;

  enemy_motion dut (.Clk(clk), .Reset(rst), .bus(ifc));
  enemy_motion #(.X_INIT(11'd2031)) dut_hi (.Clk(clk), .Reset(rst), .bus(ifc_hi));
  enemy_motion #(.X_INIT(11'd1))    dut_lo (.Clk(clk), .Reset(rst), .bus(ifc_lo));

  typedef struct {
    logic       pre_jump;
    logic       jmp;
    logic       og;
    logic [1:0] d;
    int         ex;
    int         ey;
    logic       eair;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pj, input logic j, input logic og, input logic [1:0] d,
                     input int ex, input int ey, input logic ea);
    vec_t v;
    v.pre_jump = pj; v.jmp = j; v.og = og; v.d = d; v.ex = ex; v.ey = ey; v.eair = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_jump();
    @(negedge clk);
    jump = 1'b1;
    @(posedge clk);
    #1 jump = 1'b0;
  endtask

  task automatic do_tick(input logic og, input logic j, input logic [1:0] d);
    @(negedge clk);
    on_ground = og;
    jump = j;
    dir = d;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    jump = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input logic ea);
    logic [10:0] tx;
    logic [10:0] ty;
    tx = ex[10:0];
    ty = ey[10:0];
    check({tag, " x"}, int'(ifc.enemy_x), ex);
    check({tag, " y"}, int'(ifc.enemy_y), ey);
    check({tag, " airborne"}, int'(ifc.airborne), int'(ea));
    check({tag, " loc"}, int'(ifc.enemy_loc), int'({ty[10:4], tx[10:4]}));
  endtask

  initial begin
    // pre_jump, jump_on_tick, on_ground, dir, expected x, y, airborne
    add(0,0,1,2'b00, 64, 64,0);   // land from reset fall onto ground
    add(0,0,1,2'b01, 66, 64,0);
    add(0,0,1,2'b10, 64, 64,0);
    add(0,0,1,2'b11, 64, 64,0);
    add(0,0,0,2'b00, 64, 64,1);   // walk off edge
    add(0,0,0,2'b00, 64, 65,1);
    add(0,0,0,2'b00, 64, 67,1);
    add(0,0,0,2'b00, 64, 70,1);
    add(0,0,0,2'b00, 64, 74,1);
    add(0,0,0,2'b00, 64, 79,1);
    add(0,0,0,2'b00, 64, 85,1);   // speed capped at 6 from here
    add(0,0,0,2'b00, 64, 91,1);
    add(0,0,0,2'b00, 64, 97,1);
    add(0,0,0,2'b00, 64,103,1);
    add(0,0,0,2'b00, 64,109,1);
    add(0,0,0,2'b00, 64,115,1);
    add(0,1,1,2'b00, 64,112,0);   // land with snap; jump while falling ignored
    add(0,0,1,2'b00, 64,112,0);
    add(0,0,0,2'b00, 64,112,1);
    add(0,0,0,2'b00, 64,113,1);
    add(0,0,0,2'b00, 64,115,1);
    add(0,0,0,2'b00, 64,118,1);
    add(0,0,0,2'b00, 64,122,1);
    add(0,0,0,2'b00, 64,127,1);
    add(0,0,0,2'b00, 64,133,1);
    add(0,0,0,2'b00, 64,139,1);
    add(0,0,0,2'b00, 64,145,1);
    add(0,0,0,2'b00, 64,151,1);
    add(0,0,0,2'b00, 64,157,1);
    add(0,0,0,2'b00, 64,163,1);
    add(0,0,1,2'b00, 64,160,0);   // grounded at 160
    add(1,0,1,2'b00, 64,160,1);   // jump pulsed between ticks
    add(0,0,1,2'b01, 66,152,1);
    add(0,0,1,2'b11, 66,145,1);
    add(0,0,1,2'b10, 64,139,1);
    add(0,0,1,2'b00, 64,134,1);
    add(0,0,1,2'b00, 64,130,1);
    add(0,0,1,2'b00, 64,127,1);
    add(0,0,1,2'b00, 64,125,1);   // apex reached, now falling
    add(0,0,0,2'b00, 64,126,1);
    add(0,0,1,2'b00, 64,112,0);
    add(0,1,1,2'b00, 64,112,1);   // jump on the tick edge itself
    add(0,0,1,2'b00, 64,104,1);
    add(0,0,1,2'b00, 64, 97,1);
    add(0,0,1,2'b00, 64, 91,1);
    add(0,0,1,2'b00, 64, 86,1);
    add(0,0,1,2'b00, 64, 82,1);
    add(0,0,1,2'b00, 64, 79,1);
    add(0,0,1,2'b00, 64, 77,1);
    add(0,0,1,2'b00, 64, 64,0);
    add(0,1,1,2'b00, 64, 64,1);
    add(0,0,1,2'b00, 64, 56,1);
    add(0,0,1,2'b00, 64, 49,1);
    add(0,0,1,2'b00, 64, 43,1);
    add(0,0,1,2'b00, 64, 38,1);
    add(0,0,1,2'b00, 64, 34,1);
    add(0,0,1,2'b00, 64, 31,1);
    add(0,0,1,2'b00, 64, 29,1);
    add(0,0,1,2'b00, 64, 16,0);
    add(0,1,1,2'b00, 64, 16,1);
    add(0,0,1,2'b00, 64,  8,1);
    add(0,0,1,2'b00, 64,  1,1);
    add(0,0,1,2'b00, 64,  0,1);   // top clamp, falling
    add(0,0,0,2'b00, 64,  1,1);
    add(0,0,1,2'b00, 64,  0,0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_pos("reset", 64, 64, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_jump) pulse_jump();
      do_tick(vecs[i].og, vecs[i].jmp, vecs[i].d);
      check_pos($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].eair);
    end

    // Reset in the middle of a rise, with a further jump pending.
    do_tick(1'b1, 1'b1, 2'b01);
    check_pos("rise_start", 66, 0, 1'b1);
    pulse_jump();
    #2 rst = 1'b1;
    #1;
    check_pos("async_reset", 64, 64, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    do_tick(1'b1, 1'b0, 2'b00);
    check_pos("post_reset_land", 64, 64, 1'b0);
    do_tick(1'b1, 1'b0, 2'b00);
    check_pos("post_reset_stay", 64, 64, 1'b0);

    // Horizontal saturation at both edges.
    dir_hi = 2'b01;
    dir_lo = 2'b10;
    for (int k = 0; k < 3; k++) begin
      do_tick(1'b1, 1'b0, 2'b00);
      check($sformatf("x_hi_sat%0d", k), int'(ifc_hi.enemy_x), 2032);
      check($sformatf("x_lo_sat%0d", k), int'(ifc_lo.enemy_x), 0);
    end
    dir_hi = 2'b10;
    dir_lo = 2'b01;
    do_tick(1'b1, 1'b0, 2'b00);
    check("x_hi_back", int'(ifc_hi.enemy_x), 2030);
    check("x_lo_back", int'(ifc_lo.enemy_x), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
